id_stage: RTL and testbench

// - Decode stage directly upstream of the ALU. Accepts a 32-bit RV32I instruction from fetch.
// - Extracts opcode/func3/func7/rd and builds the immediate.
// - Reads operands from an internal 32x32 register file and registers everything into an
//   ID/EX output register that drives the ALU inputs (opcode, func3, func7, imm, a, b).
// - Owns the register-file write port used by writeback. Valid/ready handshake on both sides.

---
 rtl/id_stage_if.sv | 53 +++++
 rtl/id_stage.sv | 202 ++++++++++++++++++++
 tb/tb_id_stage.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// ----------------------------------------------------------------------------
// id_stage_if : bundle of every signal of the decode stage except the clock and
//               the reset.
//
//   fetch side  : in_valid, in_ready, in_instr
//   ALU side    : out_valid, out_ready, opcode, func3, func7, imm, a, b, rd
//   control     : flush
//   writeback   : wb_en, wb_addr, wb_data
//
//   modport slave  : the decode stage (id_stage)
//   modport master : the environment that drives fetch/ALU/writeback
// ----------------------------------------------------------------------------
interface id_stage_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNC3_W  = 3;
   localparam int unsigned FUNC7_W  = 7;
   localparam int unsigned REG_W    = 5;

   // fetch handshake
   logic                in_valid;
   logic                in_ready;
   logic [INSTR_W-1:0]  in_instr;

   // ID/EX handshake and ALU inputs
   logic                out_valid;
   logic                out_ready;
   logic                flush;
   logic [OPCODE_W-1:0] opcode;
   logic [FUNC3_W-1:0]  func3;
   logic [FUNC7_W-1:0]  func7;
   logic [XLEN-1:0]     imm;
   logic [XLEN-1:0]     a;
   logic [XLEN-1:0]     b;
   logic [REG_W-1:0]    rd;

   // register-file write port
   logic                wb_en;
   logic [REG_W-1:0]    wb_addr;
   logic [XLEN-1:0]     wb_data;

   modport slave (
      input  in_valid, in_instr, out_ready, flush, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, opcode, func3, func7, imm, a, b, rd
   );

   modport master (
      output in_valid, in_instr, out_ready, flush, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, opcode, func3, func7, imm, a, b, rd
   );
endinterface

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage : RV32I decode stage feeding the ALU.
//
// Decodes opcode/func3/func7/rd and the immediate from the fetched instruction,
// reads rs1/rs2 from an internal register file (x0 hardwired to zero), and
// registers everything into the ID/EX output register. The register-file write
// port is driven by writeback. Valid/ready handshake on both sides, one cycle
// of latency from accepted instruction to ALU inputs.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low (clears ID/EX and all registers)
//   bus        id_stage_if.slave; in_ready is the only combinational output
//
// Configuration
//   ID_BYPASS_EN  when defined, the read ports are write-through: a writeback
//                 to a source register in the accept cycle is captured into
//                 a/b. When undefined, a/b capture the pre-write contents.
// ----------------------------------------------------------------------------
module id_stage #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   id_stage_if.slave bus
);

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNC3_W  = 3;
   localparam int unsigned FUNC7_W  = 7;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned IMM_W    = 12;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;

   // ---------------------------------------------------------------------
   // Field extraction from the incoming instruction
   // ---------------------------------------------------------------------
   logic [OPCODE_W-1:0] dec_opcode;
   logic [FUNC3_W-1:0]  dec_func3;
   logic [FUNC7_W-1:0]  dec_func7;
   logic [REG_W-1:0]    dec_rd;
   logic [REG_W-1:0]    dec_rs1;
   logic [REG_W-1:0]    dec_rs2;
   logic [IMM_W-1:0]    dec_imm12;
   logic [XLEN-1:0]     dec_imm;

   assign dec_opcode = bus.in_instr[6:0];
   assign dec_rd     = bus.in_instr[11:7];
   assign dec_func3  = bus.in_instr[14:12];
   assign dec_rs1    = bus.in_instr[19:15];
   assign dec_rs2    = bus.in_instr[24:20];
   assign dec_func7  = bus.in_instr[31:25];
   assign dec_imm12  = bus.in_instr[31:20];

   // R-type carries no immediate; every other opcode uses the I-type field
   always_comb begin
      dec_imm = '0;
      if (dec_opcode != OP_RTYPE) begin
         dec_imm = {{(XLEN-IMM_W){dec_imm12[IMM_W-1]}}, dec_imm12};
      end
   end

   // ---------------------------------------------------------------------
   // Register file: two combinational read ports, one write port
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] regs [NUM_REGS];
   logic            wb_write;
   logic [XLEN-1:0] rdata_a;
   logic [XLEN-1:0] rdata_b;

   assign wb_write = bus.wb_en && (bus.wb_addr != '0);

   // x0 is never written, so reads of index 0 are forced to zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= '0;
         end
      end else if (wb_write) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (dec_rs1 != '0) begin
         rdata_a = regs[dec_rs1];
      end
      if (dec_rs2 != '0) begin
         rdata_b = regs[dec_rs2];
      end
`ifdef ID_BYPASS_EN
      // write-through: a same-cycle writeback wins over the stored value
      if (wb_write && (bus.wb_addr == dec_rs1)) begin
         rdata_a = bus.wb_data;
      end
      if (wb_write && (bus.wb_addr == dec_rs2)) begin
         rdata_b = bus.wb_data;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // ID/EX output register
   // ---------------------------------------------------------------------
   logic                valid_q,  valid_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic [FUNC3_W-1:0]  func3_q,  func3_d;
   logic [FUNC7_W-1:0]  func7_q,  func7_d;
   logic [XLEN-1:0]     imm_q,    imm_d;
   logic [XLEN-1:0]     a_q,      a_d;
   logic [XLEN-1:0]     b_q,      b_d;
   logic [REG_W-1:0]    rd_q,     rd_d;
   logic [REG_W-1:0]    rs1_q,    rs1_d;
   logic [REG_W-1:0]    rs2_q,    rs2_d;

   logic ready_c;
   logic accept;

   assign ready_c = !valid_q || bus.out_ready;
   assign accept  = bus.in_valid && ready_c && !bus.flush;

   // Next-state for the ID/EX register. Data fields hold unless loaded or
   // refreshed; only valid is cleared on consume or flush.
   always_comb begin
      valid_d  = valid_q;
      opcode_d = opcode_q;
      func3_d  = func3_q;
      func7_d  = func7_q;
      imm_d    = imm_q;
      a_d      = a_q;
      b_d      = b_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;

      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         opcode_d = dec_opcode;
         func3_d  = dec_func3;
         func7_d  = dec_func7;
         imm_d    = dec_imm;
         a_d      = rdata_a;
         b_d      = rdata_b;
         rd_d     = dec_rd;
         rs1_d    = dec_rs1;
         rs2_d    = dec_rs2;
      end else if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end else if (valid_q) begin
         // stalled: keep held operands coherent with writeback
         if (wb_write && (bus.wb_addr == rs1_q)) begin
            a_d = bus.wb_data;
         end
         if (wb_write && (bus.wb_addr == rs2_q)) begin
            b_d = bus.wb_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         opcode_q <= '0;
         func3_q  <= '0;
         func7_q  <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         opcode_q <= opcode_d;
         func3_q  <= func3_d;
         func7_q  <= func7_d;
         imm_q    <= imm_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = valid_q;
   assign bus.opcode    = opcode_q;
   assign bus.func3     = func3_q;
   assign bus.func7     = func7_q;
   assign bus.imm       = imm_q;
   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.rd        = rd_q;

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage : self-checking bench for id_stage.
// A reference register file and an expected-result queue are maintained at the
// falling edge; every output is compared against the queue head (or the last
// released entry while idle). Directed sequences are followed by random traffic.
// ----------------------------------------------------------------------------
module tb_id_stage;

   localparam int unsigned XLEN = 32;

   typedef struct packed {
      logic [6:0]      opcode;
      logic [2:0]      func3;
      logic [6:0]      func7;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
   } exp_t;

   logic clk;
   logic rst_n;

   id_stage_if #(.XLEN(XLEN)) bus ();

   id_stage #(.XLEN(XLEN), .NUM_REGS(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] mregs [32];
   exp_t            q [$];
   exp_t            last;
   logic            last_ok;

   function automatic logic [XLEN-1:0] model_read(input logic [4:0] r,
                                                  input logic we, input logic [4:0] wa,
                                                  input logic [XLEN-1:0] wd,
                                                  input logic [XLEN-1:0] stored);
      if (r == 5'd0) return '0;
`ifdef ID_BYPASS_EN
      if (we && (wa == r)) return wd;
`endif
      return stored;
   endfunction

   always @(negedge clk) begin
      exp_t cur;
      exp_t nxt;
      logic acc;
      if (!rst_n) begin
         q.delete();
         last    = '0;
         last_ok = 1'b1;
         for (int i = 0; i < 32; i++) mregs[i] = '0;
      end else begin
         cur = (q.size() > 0) ? q[0] : last;
         check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         check("in_ready",  32'(bus.in_ready),  32'((q.size() == 0) || bus.out_ready));
         if ((q.size() > 0) || last_ok) begin
            check("opcode", 32'(bus.opcode), 32'(cur.opcode));
            check("func3",  32'(bus.func3),  32'(cur.func3));
            check("func7",  32'(bus.func7),  32'(cur.func7));
            check("imm",    bus.imm,         cur.imm);
            check("a",      bus.a,           cur.a);
            check("b",      bus.b,           cur.b);
            check("rd",     32'(bus.rd),     32'(cur.rd));
         end

         // effects of the coming rising edge
         acc = bus.in_valid && !bus.flush && ((q.size() == 0) || bus.out_ready);
         if (bus.flush) begin
            if (q.size() > 0) begin
               last    = q.pop_front();
               last_ok = 1'b0;
            end
         end else if ((q.size() > 0) && bus.out_ready) begin
            last    = q.pop_front();
            last_ok = 1'b1;
         end else if ((q.size() > 0) && bus.wb_en && (bus.wb_addr != 5'd0)) begin
            nxt = q[0];
            if (bus.wb_addr == nxt.rs1) nxt.a = bus.wb_data;
            if (bus.wb_addr == nxt.rs2) nxt.b = bus.wb_data;
            q[0] = nxt;
         end

         if (acc) begin
            nxt.opcode = bus.in_instr[6:0];
            nxt.rd     = bus.in_instr[11:7];
            nxt.func3  = bus.in_instr[14:12];
            nxt.rs1    = bus.in_instr[19:15];
            nxt.rs2    = bus.in_instr[24:20];
            nxt.func7  = bus.in_instr[31:25];
            nxt.imm    = (nxt.opcode == 7'h33) ? '0
                       : {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            nxt.a = model_read(nxt.rs1, bus.wb_en, bus.wb_addr, bus.wb_data, mregs[nxt.rs1]);
            nxt.b = model_read(nxt.rs2, bus.wb_en, bus.wb_addr, bus.wb_data, mregs[nxt.rs2]);
            q.push_back(nxt);
         end

         if (bus.wb_en && (bus.wb_addr != 5'd0)) mregs[bus.wb_addr] = bus.wb_data;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] addr, input logic [XLEN-1:0] data);
      bus.wb_en   = 1'b1;
      bus.wb_addr = addr;
      bus.wb_data = data;
      tick();
      bus.wb_en   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] instr;
      int          budget;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h002081B3;
      bus.out_ready = 1'b1;
      bus.flush     = 1'b0;
      bus.wb_en     = 1'b1;
      bus.wb_addr   = 5'd1;
      bus.wb_data   = 32'h1234;
      tick();
      tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_opcode",    32'(bus.opcode),    32'd0);
      check("rst_imm",       bus.imm,            32'd0);
      check("rst_a",         bus.a,              32'd0);
      check("rst_b",         bus.b,              32'd0);
      check("rst_rd",        32'(bus.rd),        32'd0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      bus.wb_en    = 1'b0;
      tick();

      // every register reads zero after reset
      for (int i = 1; i < 32; i++) begin
         instr        = {7'd0, 5'((i % 31) + 1), 5'(i), 3'd0, 5'd0, 7'h33};
         bus.in_instr = instr;
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      tick();

      // basic decode: add x3,x1,x2
      wb(5'd1, 32'd5);
      wb(5'd2, 32'd7);
      bus.in_instr = 32'h002081B3;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("add_valid",  32'(bus.out_valid), 32'd1);
      check("add_opcode", 32'(bus.opcode),    32'h33);
      check("add_func3",  32'(bus.func3),     32'd0);
      check("add_func7",  32'(bus.func7),     32'd0);
      check("add_a",      bus.a,              32'd5);
      check("add_b",      bus.b,              32'd7);
      check("add_rd",     32'(bus.rd),        32'd3);
      check("add_imm",    bus.imm,            32'd0);

      // immediate sign extension: addi x1,x1,-1
      bus.in_instr = 32'hFFF08093;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("addi_imm",    bus.imm,         32'hFFFFFFFF);
      check("addi_opcode", 32'(bus.opcode), 32'h13);
      check("addi_func3",  32'(bus.func3),  32'd0);
      tick();

      // backpressure with operand refresh
      bus.out_ready = 1'b0;
      bus.in_instr  = 32'h002081B3;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_instr  = 32'hFFF08093;
      for (int k = 0; k < 3; k++) begin
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         if (k == 1) begin
            bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'd9;
         end
         tick();
         bus.wb_en = 1'b0;
      end
      check("bp_b_refresh", bus.b,              32'd9);
      check("bp_a_hold",    bus.a,              32'd5);
      check("bp_rd_hold",   32'(bus.rd),        32'd3);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bp_release", 32'(bus.out_valid), 32'd0);

      // flush while holding, with a simultaneous in_valid
      bus.out_ready = 1'b0;
      bus.in_instr  = 32'h002081B3;
      bus.in_valid  = 1'b1;
      tick();
      bus.flush    = 1'b1;
      bus.in_instr = 32'hFFF08093;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("flush_no_capture", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;

      // writes to x0 are discarded: add x5,x0,x1
      wb(5'd0, 32'hDEAD);
      bus.in_instr = 32'h001002B3;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("x0_read", bus.a, 32'd0);
      check("x0_b",    bus.b, 32'd5);

      // same-cycle writeback to a source register
      bus.in_instr = 32'h002081B3;
      bus.in_valid = 1'b1;
      bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h11;
      tick();
      bus.in_valid = 1'b0;
      bus.wb_en    = 1'b0;
`ifdef ID_BYPASS_EN
      check("bypass_a", bus.a, 32'h11);
`else
      check("bypass_a", bus.a, 32'd5);
`endif
      tick();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_instr  = $urandom();
         if ($urandom_range(0, 2) == 0) bus.in_instr[6:0] = 7'h33;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 15) == 0);
         bus.wb_en     = 1'($urandom_range(0, 1));
         bus.wb_addr   = 5'($urandom_range(0, 7));
         bus.wb_data   = $urandom();
         tick();
      end

      // drain
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.wb_en     = 1'b0;
      bus.out_ready = 1'b1;
      budget = 0;
      while ((q.size() != 0) && (budget < 20)) begin
         tick();
         budget++;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
